// File: rtl/present_nullfresh_round_ctrl.sv
// Round controller for the 3-share NullFresh masked PRESENT-80 core.
// Sequences load, SBOX_LAT-cycle masked rounds, the final key addition and
// the done strobe. All outputs come straight from flops; the next-state
// logic also computes the next output values so the flops hold them in the
// same cycle as the matching state.
module present_nullfresh_round_ctrl #(
    parameter int unsigned SBOX_LAT = 4,
    parameter int unsigned ROUNDS   = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       sel_load,
    output logic       en_state,
    output logic       en_key,
    output logic       last_addkey,
    output logic [4:0] round_cnt,
    output logic [3:0] stage_cnt
);

    localparam int unsigned ROUND_W = 5;
    localparam int unsigned STAGE_W = 4;

    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(SBOX_LAT - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS);

    // Reject parameter values the counters cannot represent.
    if (SBOX_LAT < 1 || SBOX_LAT > 15) begin : g_bad_sbox_lat
        $error("present_nullfresh_round_ctrl: SBOX_LAT must be in 1..15");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_nullfresh_round_ctrl: ROUNDS must be in 1..31");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [ROUND_W-1:0]   round_d;
    logic [STAGE_W-1:0]   stage_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 sel_load_d;
    logic                 en_state_d;
    logic                 en_key_d;
    logic                 last_addkey_d;
    logic                 round_end_d;

    // Next state, next counters and the outputs that go with them.
    always_comb begin
        state_d = state_q;
        round_d = round_cnt;
        stage_d = stage_cnt;

        case (state_q)
            S_IDLE: begin
                round_d = '0;
                stage_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                round_d = ROUND_W'(1);
                stage_d = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (stage_cnt == STAGE_LAST) begin
                    stage_d = '0;
                    if (round_cnt == ROUND_LAST) begin
                        state_d = S_FINAL;
                    end else begin
                        round_d = round_cnt + ROUND_W'(1);
                    end
                end else begin
                    stage_d = stage_cnt + STAGE_W'(1);
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = '0;
                stage_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
                stage_d = '0;
            end
        endcase

        // Moore decode of the upcoming state/counters, captured below.
        round_end_d   = (state_d == S_ROUND) && (stage_d == STAGE_LAST);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
        sel_load_d    = (state_d == S_LOAD);
        last_addkey_d = (state_d == S_FINAL);
        en_state_d    = (state_d == S_LOAD) || round_end_d || (state_d == S_FINAL);
        en_key_d      = (state_d == S_LOAD) || round_end_d;
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_cnt   <= '0;
            stage_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sel_load    <= 1'b0;
            en_state    <= 1'b0;
            en_key      <= 1'b0;
            last_addkey <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_cnt   <= round_d;
            stage_cnt   <= stage_d;
            busy        <= busy_d;
            done        <= done_d;
            sel_load    <= sel_load_d;
            en_state    <= en_state_d;
            en_key      <= en_key_d;
            last_addkey <= last_addkey_d;
        end
    end

endmodule

// File: tb/tb_present_nullfresh_round_ctrl.sv
// Bench for present_nullfresh_round_ctrl: a default instance and a
// SBOX_LAT=1/ROUNDS=1 corner instance share one stimulus stream. The
// reference model tracks only "cycles since the start was accepted" and
// derives every expected output from the documented cycle arithmetic.
module tb_present_nullfresh_round_ctrl;

    localparam int LAT_A    = 4;
    localparam int ROUNDS_A = 31;
    localparam int LAT_B    = 1;
    localparam int ROUNDS_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;

    logic       a_busy, a_done, a_sel_load, a_en_state, a_en_key, a_last_addkey;
    logic [4:0] a_round_cnt;
    logic [3:0] a_stage_cnt;
    logic       b_busy, b_done, b_sel_load, b_en_state, b_en_key, b_last_addkey;
    logic [4:0] b_round_cnt;
    logic [3:0] b_stage_cnt;

    present_nullfresh_round_ctrl #(.SBOX_LAT(LAT_A), .ROUNDS(ROUNDS_A)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .busy(a_busy), .done(a_done), .sel_load(a_sel_load),
        .en_state(a_en_state), .en_key(a_en_key), .last_addkey(a_last_addkey),
        .round_cnt(a_round_cnt), .stage_cnt(a_stage_cnt)
    );

    present_nullfresh_round_ctrl #(.SBOX_LAT(LAT_B), .ROUNDS(ROUNDS_B)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .busy(b_busy), .done(b_done), .sel_load(b_sel_load),
        .en_state(b_en_state), .en_key(b_en_key), .last_addkey(b_last_addkey),
        .round_cnt(b_round_cnt), .stage_cnt(b_stage_cnt)
    );

    typedef struct {
        logic busy;
        logic done;
        logic sel_load;
        logic en_state;
        logic en_key;
        logic last_addkey;
        int   round_cnt;
        int   stage_cnt;
        bit   chk_round;
        bit   chk_stage;
    } exp_t;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int ka     = 0;
    int kb     = 0;
    bit b2b    = 1'b0;
    int last_done_a = -1;
    int n_gaps = 0;

    // Expected outputs k cycles after the accepting edge (k=0: idle).
    function automatic exp_t model(int lat, int rounds, int k);
        exp_t e;
        int   j;
        e = '{default: 0};
        e.chk_round = 1'b1;
        e.chk_stage = 1'b1;
        if (k == 0) return e;
        e.busy = 1'b1;
        if (k == 1) begin
            e.sel_load  = 1'b1;
            e.en_state  = 1'b1;
            e.en_key    = 1'b1;
            e.chk_round = 1'b0;
            e.chk_stage = 1'b0;
        end else if (k <= 1 + rounds * lat) begin
            j           = k - 2;
            e.round_cnt = j / lat + 1;
            e.stage_cnt = j % lat;
            e.en_state  = (e.stage_cnt == lat - 1);
            e.en_key    = e.en_state;
        end else if (k == 2 + rounds * lat) begin
            e.last_addkey = 1'b1;
            e.en_state    = 1'b1;
            e.round_cnt   = rounds;
            e.chk_stage   = 1'b0;
        end else begin
            e.done      = 1'b1;
            e.round_cnt = rounds;
            e.chk_stage = 1'b0;
        end
        // With a single pipeline stage the stage counter is always zero.
        if (lat == 1) begin
            e.chk_stage = 1'b1;
            e.stage_cnt = 0;
        end
        return e;
    endfunction

    // Advance the cycle position on a clock edge.
    function automatic int next_k(int k, int lat, int rounds, logic r, logic s);
        if (r) return 0;
        if (k == 0) return s ? 1 : 0;
        if (k >= 3 + rounds * lat) return 0;
        return k + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_dut(input string who, input exp_t e,
                             input logic busy, input logic done, input logic sel_load,
                             input logic en_state, input logic en_key, input logic last_addkey,
                             input logic [4:0] round_cnt, input logic [3:0] stage_cnt);
        check({who, ".busy"},        32'(busy),        32'(e.busy));
        check({who, ".done"},        32'(done),        32'(e.done));
        check({who, ".sel_load"},    32'(sel_load),    32'(e.sel_load));
        check({who, ".en_state"},    32'(en_state),    32'(e.en_state));
        check({who, ".en_key"},      32'(en_key),      32'(e.en_key));
        check({who, ".last_addkey"}, 32'(last_addkey), 32'(e.last_addkey));
        if (e.chk_round) check({who, ".round_cnt"}, 32'(round_cnt), 32'(e.round_cnt));
        if (e.chk_stage) check({who, ".stage_cnt"}, 32'(stage_cnt), 32'(e.stage_cnt));
    endtask

    // Drive one cycle of inputs, clock it, then compare both instances.
    task automatic step(input logic r, input logic s);
        @(negedge clk);
        rst   = r;
        start = s;
        @(posedge clk);
        ka = next_k(ka, LAT_A, ROUNDS_A, r, s);
        kb = next_k(kb, LAT_B, ROUNDS_B, r, s);
        #1;
        cyc++;
        check_dut("a", model(LAT_A, ROUNDS_A, ka), a_busy, a_done, a_sel_load,
                  a_en_state, a_en_key, a_last_addkey, a_round_cnt, a_stage_cnt);
        check_dut("b", model(LAT_B, ROUNDS_B, kb), b_busy, b_done, b_sel_load,
                  b_en_state, b_en_key, b_last_addkey, b_round_cnt, b_stage_cnt);
        if (b2b && a_done === 1'b1) begin
            if (last_done_a >= 0) begin
                check("b2b_done_gap", 32'(cyc - last_done_a), 32'd128);
                n_gaps++;
            end
            last_done_a = cyc;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;

        // Reset held with start asserted.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Nominal run with stray starts at cycles 10 and 126.
        step(1'b0, 1'b1);
        for (int i = 1; i <= 132; i++) step(1'b0, (i == 10) || (i == 126));

        // Reset in cycle 60, then a fresh run.
        step(1'b0, 1'b1);
        for (int i = 1; i <= 59; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 1; i <= 132; i++) step(1'b0, 1'b0);

        // Back-to-back with start held high.
        b2b         = 1'b1;
        last_done_a = -1;
        for (int i = 0; i < 420; i++) step(1'b0, 1'b1);
        b2b = 1'b0;
        check("b2b_gaps_seen", 32'(n_gaps >= 2), 32'd1);
        step(1'b1, 1'b0);

        // Random start/reset traffic.
        for (int i = 0; i < 2500; i++) begin
            step(1'(($urandom % 300) == 0), 1'(($urandom % 16) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/present_nullfresh_round_ctrl.md
# present_nullfresh_round_ctrl

Round controller for the 3-share (d=2) NullFresh masked PRESENT-80 encryption core. It sequences plaintext/key loading, waits out the pipelined masked S-box for each round, and strobes the state and key-register enables. It also drives the round counter for the key schedule and flags the final key addition. It sits upstream of the per-share XOR layers (AddRoundKey / share compression) and the share registers, and drives their muxes and enables. It processes no data itself.

## Interface
- SBOX_LAT, 4, masked S-box pipeline depth in cycles; legal range 1..15
- ROUNDS, 31, number of S-box/pLayer rounds; legal range 1..31
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a new encryption; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; ciphertext shares are valid this cycle
- sel_load  out  1  state/key input muxes select plaintext/key shares
- en_state  out  1  capture enable for the 3-share 64-bit state registers
- en_key  out  1  capture enable for the 3-share 80-bit key registers
- last_addkey  out  1  selects the final AddRoundKey (K32) path into the output XOR layer
- round_cnt  out  5  PRESENT round counter fed to the key-schedule counter XOR
- stage_cnt  out  4  current S-box pipeline stage (0..SBOX_LAT-1)

## Operation
- Moore FSM with states IDLE, LOAD, ROUND, FINAL, DONE. All outputs decode from registered state and counters only, with no combinational path from start.
- IDLE:
  - All outputs 0.
  - If start=1 at a clock edge, go to LOAD.
- LOAD (1 cycle):
  - sel_load=en_state=en_key=1.
  - Set round_cnt:=1 and stage_cnt:=0.
  - Go to ROUND.
- ROUND:
  - stage_cnt advances 0..SBOX_LAT-1.
  - On the stage_cnt=SBOX_LAT-1 cycle, en_state=en_key=1 (round end). That cycle also:
    - if round_cnt<ROUNDS: round_cnt increments, stage_cnt wraps to 0, stay in ROUND;
    - if round_cnt=ROUNDS: round_cnt holds, go to FINAL.
  - Outside the round-end cycle, en_state=en_key=0.
- FINAL (1 cycle):
  - last_addkey=1, en_state=1, en_key=0.
  - Go to DONE.
- DONE (1 cycle):
  - done=1, then go to IDLE.
  - round_cnt and stage_cnt are cleared on the transition into IDLE.
- start is ignored in every state other than IDLE; there is no queuing.
- round_cnt never exceeds ROUNDS, so the 5-bit counter cannot wrap. stage_cnt never exceeds SBOX_LAT-1.
- Elaboration must fail (generate-time check) if SBOX_LAT=0, SBOX_LAT>15, ROUNDS=0 or ROUNDS>31.

## Timing
- Reset:
  - rst=1 at an edge forces IDLE and clears round_cnt and stage_cnt. All outputs read 0 in the following cycle.
  - rst takes priority over start and over any mid-operation state. An encryption in progress is abandoned with no done pulse.
- Let E0 be the edge that samples start=1 in IDLE. Cycles below are numbered after E0.
  - LOAD is cycle 1.
  - Round r occupies cycles 2+(r-1)·SBOX_LAT .. 1+r·SBOX_LAT.
  - FINAL is cycle 2+ROUNDS·SBOX_LAT.
  - done is cycle 3+ROUNDS·SBOX_LAT.
  - Defaults: LOAD at 1, round 31 at 122..125, FINAL at 126, done at 127.
- A start held high through DONE is sampled again in IDLE, one cycle after done. Back-to-back encryptions therefore run with a 1-cycle IDLE gap.
- busy rises in cycle 1 and falls in the cycle after done.

## Test plan
- Reset: apply rst=1 for 2 cycles with start=1 -> busy, done and all enables stay 0; round_cnt=0, stage_cnt=0.
- Nominal run, defaults: start pulse at E0 ->
  - sel_load=1 only in cycle 1;
  - en_state/en_key pulse in cycles 5, 9, …, 125 (31 pulses);
  - round_cnt reads 1 in cycles 2..5 and 31 in cycles 122..126;
  - last_addkey=1 in cycle 126 only;
  - done=1 in cycle 127 only.
- Start while busy: extra start pulses at cycles 10 and 126 -> timing identical to the nominal run; no restart.
- Reset mid-operation: rst=1 in cycle 60 -> IDLE from cycle 61 and no done pulse. A fresh start afterwards gives done exactly 127 cycles after its sampling edge.
- Parameter corner, SBOX_LAT=1, ROUNDS=1:
  - done in cycle 4;
  - en_state=1 in cycles 1, 2, 3;
  - en_key=1 in cycles 1, 2;
  - stage_cnt stays 0 throughout.
- Back-to-back: start held high continuously -> done pulses 128 cycles apart, and busy is low for exactly one cycle between runs.
